// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned shift-add multiplier with architectural HI/LO
// registers. Sits beside the ALU result stage and shares its operand and
// function-code inputs. A MULTU code starts an operation: operands are
// captured on that edge (E0), one product bit is retired per cycle, and on
// edge E(WIDTH) the full 2*WIDTH-bit product lands in {hi, lo}.
//
// Configuration macro: MULT_SIGNED_EN
//   When defined, MULT_CODE also starts an operation. The magnitudes of a and b
//   are multiplied, and the product is negated at completion if the operand
//   signs differed. When undefined, MULT_CODE behaves like any other
//   non-multiply code and no sign logic exists.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   a       in   [WIDTH-1:0] multiplicand
//   b       in   [WIDTH-1:0] multiplier
//   signal  in   [5:0] ALU function code
//   hi      out  [WIDTH-1:0] architectural HI (upper product half)
//   lo      out  [WIDTH-1:0] architectural LO (lower product half)
//   busy    out  high while iterating
//   done    out  one-cycle pulse when hi/lo take a new product
module multu_hilo #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = 6'd25,
  parameter logic [5:0] MULT_CODE  = 6'd24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       signal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // One extra bit so the count can sit at WIDTH after the final step.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;     // upper half: partial sum, lower half: multiplier bits
  logic [CW-1:0]      cnt;
  logic               done_q;

  logic               start;    // a multiply code is present
  logic               hold;     // the code that started the current operation is held
  logic               last;     // this RUN step retires the final bit
  logic [WIDTH-1:0]   a_op;
  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     upper;    // WIDTH+1 bits keeps the carry out of the add
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] result;

  assign last = (cnt == CW'(WIDTH - 1));

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole register right, pulling the carry in on top.
  always_comb begin
    upper     = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                        : {1'b0, prod[2*WIDTH-1:WIDTH]};
    prod_step = {upper, prod[WIDTH-1:1]};
  end

`ifdef MULT_SIGNED_EN
  logic       neg;
  logic [5:0] start_code;
  logic       is_signed;

  always_comb begin
    is_signed = (signal == MULT_CODE);
    start     = (signal == MULTU_CODE) || is_signed;
    hold      = (signal == start_code);
    // Magnitudes only for a signed start; -x is also correct for the most
    // negative value when read back as unsigned.
    a_op      = (is_signed && a[WIDTH-1]) ? -a : a;
    b_op      = (is_signed && b[WIDTH-1]) ? -b : b;
    result    = neg ? -prod_step : prod_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg        <= 1'b0;
      start_code <= 6'd0;
    end else if (state == IDLE && start) begin
      neg        <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      start_code <= signal;
    end
  end
`else
  always_comb begin
    start  = (signal == MULTU_CODE);
    hold   = (signal == MULTU_CODE);
    a_op   = a;
    b_op   = b;
    result = prod_step;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      // Holding the start code parks here so it cannot retrigger.
      DONE:    if (!hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state == RUN);
    done = done_q;
  end

  // Datapath and architectural registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_op;
            prod  <= {{WIDTH{1'b0}}, b_op};
            cnt   <= '0;
          end
        end
        RUN: begin
          prod <= prod_step;
          cnt  <= cnt + CW'(1);
          if (last) begin
            {hi, lo} <= result;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo. The reference model is plain 64-bit
// arithmetic on the captured operands; the bench tracks the architectural
// HI/LO value it expects and checks busy/done timing edge by edge.
module tb_multu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [5:0]   signal;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural {hi, lo}.
  logic [2*W-1:0] exp_hilo = '0;

  // Non-multiply ALU codes used as interference.
  logic [5:0] other_codes [9] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd0, 6'd61, 6'd60};

  multu_hilo #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .signal (signal),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    signal = 6'd0;
    tick();
    tick();
  endtask

  // Runs one operation and checks busy, done and hi/lo on edges E0..E34.
  // disturb: scrambles a/b and toggles the code during RUN, which must not
  // restart or alter the operation.
  task automatic do_multiply(input string name, input logic [W-1:0] x,
                             input logic [W-1:0] y, input bit disturb,
                             input bit signed_op);
    logic [2*W-1:0] prev;
    logic [2*W-1:0] want;
    logic [5:0]     code;
    logic [2*W-1:0] got;
    prev = exp_hilo;
    if (signed_op) begin
      longint sp;
      sp   = longint'($signed(x)) * longint'($signed(y));
      want = 64'(sp);
      code = 6'd24;
    end else begin
      want = 64'(x) * 64'(y);
      code = 6'd25;
    end
    a = x;
    b = y;
    signal = code;
    for (int k = 0; k <= 34; k++) begin
      tick();
      if (disturb && k >= 3 && k <= 20) begin
        a = $urandom;
        b = $urandom;
        signal = (k % 2 == 1) ? other_codes[$urandom_range(0, 8)] : code;
      end else begin
        signal = code;
      end
      got = {hi, lo};
      n_checks++;
      if (busy !== (k <= 31)) begin
        n_fail++;
        $display("FAIL %s busy E%0d: got %b want %b", name, k, busy, (k <= 31));
      end
      n_checks++;
      if (done !== (k == 32)) begin
        n_fail++;
        $display("FAIL %s done E%0d: got %b want %b", name, k, done, (k == 32));
      end
      n_checks++;
      if (got !== ((k >= 32) ? want : prev)) begin
        n_fail++;
        $display("FAIL %s hilo E%0d: got %h want %h", name, k, got, (k >= 32) ? want : prev);
      end
    end
    exp_hilo = want;
    go_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    signal = 6'd0;
    a = '0;
    b = '0;
    tick();
    tick();
    reset = 1'b0;
    exp_hilo = '0;
    n_checks++;
    if ({hi, lo, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
    end
  endtask

  task automatic test_basic();
    do_multiply("basic_3x5", 32'd3, 32'd5, 1'b0, 1'b0);
  endtask

  task automatic test_max();
    do_multiply("max_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL max_const: got hi=%h lo=%h want hi=fffffffe lo=00000001", hi, lo);
    end
  endtask

  // Code held long after completion must not retrigger; a fresh code must.
  task automatic test_hold_retrigger();
    int pulses;
    pulses = 0;
    a = 32'd11;
    b = 32'd13;
    signal = 6'd25;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    signal = 6'd61;
    tick();
    if (done === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if ({hi, lo} !== 64'd143) begin
      n_fail++;
      $display("FAIL hold_product: got %h want %h", {hi, lo}, 64'd143);
    end
    exp_hilo = 64'd143;
    do_multiply("retrigger_7x6", 32'd7, 32'd6, 1'b0, 1'b0);
  endtask

  // Reset asserted for edge E10 aborts the run with no done pulse.
  task automatic test_reset_abort();
    a = 32'd1000;
    b = 32'd1000;
    signal = 6'd25;
    for (int k = 0; k <= 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    signal = 6'd0;
    exp_hilo = '0;
    n_checks++;
    if ({hi, lo, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d: got busy=%b done=%b want 0 0", k, busy, done);
      end
    end
  endtask

  task automatic test_operand_change();
    do_multiply("opchange_1000", 32'd1000, 32'd1000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_multiply($sformatf("rand%0d", i), W'($urandom), W'($urandom), (i % 2 == 1), 1'b0);
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    do_multiply("signed_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_fail++;
      $display("FAIL signed_const: got hi=%h lo=%h want hi=ffffffff lo=fffffff1", hi, lo);
    end
    for (int i = 0; i < 4; i++) begin
      do_multiply($sformatf("srand%0d", i), W'($urandom), W'($urandom), 1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    signal = 6'd0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_max();
    test_hold_retrigger();
    test_reset_abort();
    test_operand_change();
    test_random();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Sequential 32-bit unsigned shift-add multiplier with architectural HI/LO registers.
- Sits beside the ALU result stage and shares its operand and function-code inputs (a, b, signal).
- Produces the hi/lo values that the ALU result mux returns on the HI (61) and LO (60) function codes.
- Multi-cycle: an operation is started by the MULTU code (25) and completes WIDTH cycles later.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH; one iteration per bit.
- MULTU_CODE, 6'd25, function code that starts an unsigned multiply.
- MULT_CODE, 6'd24, function code that starts a signed multiply; used only with MULT_SIGNED_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signal  input  6  ALU function code.
- hi  output  WIDTH  architectural HI register (upper product half).
- lo  output  WIDTH  architectural LO register (lower product half).
- busy  output  1  high while the iteration is in progress.
- done  output  1  one-cycle pulse when hi/lo take a new product.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, cnt=0, working regs=0. Reset has priority over every other event.
- State machine: IDLE, RUN, DONE.
- IDLE -> RUN on the edge (E0) where signal==MULTU_CODE.
  - At E0, latch mcand<=a and prod<={WIDTH'b0, b}; cnt<=0; busy<=1.
  - Operands are captured only at E0; changes to a/b afterwards are ignored.
- RUN: one step per edge.
  - If prod[0], upper = prod[2W-1:W] + mcand, computed at W+1 bits to keep the carry.
  - prod <= {carry, upper, prod[W-1:1]}: a right shift by 1 that pulls the carry in.
  - cnt increments.
  - On the step with cnt==WIDTH-1, the final product goes directly into {hi, lo}, done<=1, busy<=0, state->DONE.
  - That final step is edge E32 for WIDTH=32.
- DONE: done returns to 0 after one cycle.
  - Stays in DONE while signal==MULTU_CODE, so a held code never retriggers.
  - Goes to IDLE on the first edge where signal!=MULTU_CODE.
  - A new operation needs signal to leave MULTU_CODE and return.
- hi/lo visibility:
  - hi/lo change only at completion or reset.
  - During RUN they hold the previous product; reads of HI/LO mid-operation return old values.
- Counter: ceil(log2(WIDTH))+1 bits; no wrap occurs because the exit happens at WIDTH-1.
- Arithmetic:
  - Unsigned modulo 2^(2W); the full 64-bit product is exact, with no overflow possible.
  - 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
- Other codes (AND, OR, ADD, SUB, SLT, SRL, SLL, HI, LO) have no effect on state, except for leaving DONE.
- MULTU while busy is ignored (no restart).
- Reset mid-RUN: abort on that edge and clear to reset values; no done pulse.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- When defined:
  - signal==MULT_CODE also starts an operation.
  - At E0, a sign flag = a[W-1]^b[W-1] is latched, and absolute values of a and b enter the datapath.
  - At completion, the 2W-bit product is two's-complement negated if the flag is set, then written to {hi, lo}.
  - Latency is identical to MULTU.
  - DONE holds while signal equals the code that started the operation.
- When undefined: MULT_CODE is treated like any other non-multiply code, and no sign logic is synthesized.

Test Plan:
- Reset held 2 cycles -> hi=0, lo=0, busy=0, done=0.
- signal=25, a=3, b=5, held 35 cycles -> busy=1 from E0 through E31; done pulse at E32 only; hi=0, lo=15.
- a=0xFFFFFFFF, b=0xFFFFFFFF, MULTU -> hi=0xFFFFFFFE, lo=0x00000001 at E32; hi/lo keep the prior product during E1..E31.
- MULTU held 40 cycles, then signal=61 for 1 cycle, then MULTU with a=7, b=6 -> exactly two done pulses; final lo=42, hi=0.
- MULTU a=1000, b=1000; reset=1 at E10; a changed at E5 in a separate run -> reset aborts (hi=lo=0, no done); the changed-a run still yields lo=1000000.
- MULT_SIGNED_EN only: signal=24, a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E32.
